// File: rtl/perf_counter_bank_pkg.sv
// Shared types and register-map helpers for the performance counter bank.
package perf_counter_bank_pkg;

    // CPU-side word type of the memory port.
    typedef logic [15:0] lc3b_word;

    // Access FSM: wait for an in-window request, then answer for one cycle.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } perf_state_t;

    // Control registers sit directly after the counter words.
    localparam int CTRL_REL = 0;
    localparam int OVF_REL  = 1;

    // Number of 16-bit words a counter of the given width occupies.
    function automatic int words_per_cnt(input int cnt_width);
        return cnt_width / 16;
    endfunction

    // Offset of CTRL within the window.
    function automatic int ctrl_offset(input int num_cnt, input int cnt_width);
        return num_cnt * words_per_cnt(cnt_width) + CTRL_REL;
    endfunction

    // Offset of OVF within the window.
    function automatic int ovf_offset(input int num_cnt, input int cnt_width);
        return num_cnt * words_per_cnt(cnt_width) + OVF_REL;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One presettable event counter with saturate/wrap behaviour and an
// overflow pulse raised whenever an increment is applied at all-ones.
module perf_counter #(
    parameter int CNT_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 freeze_i,
    input  logic                 clear_i,
    input  logic                 load_lo_i,
    input  logic                 load_hi_i,
    input  logic [15:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ovf_set_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] load_value;
    logic                 all_ones;
    logic                 inc_apply;

    // A write only replaces the addressed 16-bit half; the other half is kept.
    if (CNT_WIDTH == 32) begin : g_wide
        assign load_value = {load_hi_i ? wdata_i : count_q[31:16],
                             load_lo_i ? wdata_i : count_q[15:0]};
    end else begin : g_narrow
        logic unused_load_hi;
        assign unused_load_hi = load_hi_i;
        assign load_value     = wdata_i;
    end

    assign all_ones  = &count_q;
    // Increments lose to clear and to CPU writes in the same cycle.
    assign inc_apply = inc_i && !freeze_i && !clear_i && !load_lo_i && !load_hi_i;
    assign ovf_set_o = inc_apply && all_ones;
    assign count_o   = count_q;

    // Next count: clear, then CPU load, then increment (saturating or wrapping).
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_lo_i || load_hi_i) begin
            count_d = load_value;
        end else if (inc_apply) begin
            if (all_ones) begin
                count_d = SATURATE ? count_q : '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped performance counter bank. In-window accesses are answered
// locally one cycle after acceptance; everything else passes straight
// through to the downstream memory port.
//
// Handshake: read_i/write_i are held with a stable address until resp_o;
// an in-window request is accepted on an edge where the FSM is IDLE, and
// resp_o is high for exactly the following cycle.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int          NUM_CNT   = 10,
    parameter int          CNT_WIDTH = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFFE0,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [15:0]        address_i,
    input  logic [15:0]        wdata_i,
    output logic [15:0]        rdata_o,
    output logic               resp_o,
    input  logic [NUM_CNT-1:0] inc_i,
    input  logic [15:0]        rdata_pass_i,
    input  logic               resp_pass_i,
    output logic               read_pass_o,
    output logic               write_pass_o,
    output logic [15:0]        address_pass_o,
    output logic [15:0]        wdata_pass_o,
    output logic               dbg_state_o
);

    localparam int       WPC      = words_per_cnt(CNT_WIDTH);
    localparam int       CNT_WORDS = NUM_CNT * WPC;
    localparam lc3b_word CTRL_OFF = lc3b_word'(ctrl_offset(NUM_CNT, CNT_WIDTH));
    localparam lc3b_word OVF_OFF  = lc3b_word'(ovf_offset(NUM_CNT, CNT_WIDTH));
    localparam lc3b_word WIN_SIZE = lc3b_word'(CNT_WORDS + 2);

    perf_state_t          state_q;
    lc3b_word             resp_data_q;
    lc3b_word             shadow_q;
    lc3b_word             shadow_d;
    logic                 freeze_q;
    logic                 freeze_d;
    logic [NUM_CNT-1:0]   ovf_q;
    logic [NUM_CNT-1:0]   ovf_d;

    lc3b_word             offset;
    logic                 in_window;
    logic                 accept;
    logic                 rd_commit;
    logic                 wr_commit;
    logic                 hit_ctrl;
    logic                 hit_ovf;
    logic                 clear_all;
    logic                 lo_word_hit;
    lc3b_word             read_value;
    lc3b_word             shadow_next;

    logic [NUM_CNT-1:0]   load_lo;
    logic [NUM_CNT-1:0]   load_hi;
    logic [NUM_CNT-1:0]   ovf_set;
    logic [CNT_WIDTH-1:0] count_w [NUM_CNT];
    logic [31:0]          cnt_ext [NUM_CNT];

    // Window decode.
    assign offset    = address_i - BASE_ADDR;
    assign in_window = (address_i >= BASE_ADDR) && (offset < WIN_SIZE);

    // Acceptance; read wins when both strobes are high.
    assign accept    = (state_q == IDLE) && in_window && (read_i || write_i);
    assign rd_commit = accept && read_i;
    assign wr_commit = accept && !read_i && write_i;
    assign hit_ctrl  = (offset == CTRL_OFF);
    assign hit_ovf   = (offset == OVF_OFF);
    assign clear_all = wr_commit && hit_ctrl && wdata_i[1];

    // Counter instances with their word-level write strobes.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign load_lo[i] = wr_commit && (offset == lc3b_word'(i * WPC));
        assign load_hi[i] = wr_commit && (WPC == 2) && (offset == lc3b_word'(i * WPC + 1));
        assign cnt_ext[i] = 32'(count_w[i]);

        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .inc_i     (inc_i[i]),
            .freeze_i  (freeze_q),
            .clear_i   (clear_all),
            .load_lo_i (load_lo[i]),
            .load_hi_i (load_hi[i]),
            .wdata_i   (wdata_i),
            .count_o   (count_w[i]),
            .ovf_set_o (ovf_set[i])
        );
    end

    // Read mux; a low-word hit also prepares the high half for the shadow.
    always_comb begin
        read_value  = '0;
        shadow_next = '0;
        lo_word_hit = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (offset == lc3b_word'(i * WPC)) begin
                read_value  = cnt_ext[i][15:0];
                shadow_next = cnt_ext[i][31:16];
                lo_word_hit = 1'b1;
            end
            if ((WPC == 2) && (offset == lc3b_word'(i * WPC + 1))) begin
                read_value = shadow_q;
            end
        end
        if (hit_ctrl) begin
            read_value = {15'b0, freeze_q};
        end
        if (hit_ovf) begin
            read_value = 16'(ovf_q);
        end
    end

    // Next state of shadow, CTRL and the sticky overflow flags.
    always_comb begin
        shadow_d = shadow_q;
        freeze_d = freeze_q;
        ovf_d    = ovf_q;
        if (rd_commit && lo_word_hit) begin
            shadow_d = shadow_next;
        end
        if (wr_commit && hit_ctrl) begin
            freeze_d = wdata_i[0];
        end
        if (wr_commit && hit_ovf) begin
            ovf_d = ovf_q & ~wdata_i[NUM_CNT-1:0];
        end
        // A new overflow on this edge beats a simultaneous clear.
        ovf_d = ovf_d | ovf_set;
    end

    // Shadow, CTRL and OVF registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            freeze_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            freeze_q <= freeze_d;
            ovf_q    <= ovf_d;
        end
    end

    // Access FSM with the registered response word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_data_q <= rd_commit ? read_value : 16'h0000;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    resp_data_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // CPU return and downstream forwarding.
    assign resp_o         = in_window ? (state_q == RESP) : resp_pass_i;
    assign rdata_o        = in_window ? ((state_q == RESP) ? resp_data_q : 16'h0000) : rdata_pass_i;
    assign read_pass_o    = in_window ? 1'b0 : read_i;
    assign write_pass_o   = in_window ? 1'b0 : write_i;
    assign address_pass_o = address_i;
    assign wdata_pass_o   = wdata_i;
    assign dbg_state_o    = state_q;

endmodule
